// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction Decode stage of the 5-stage RISC-V pipeline.
//                Decodes control, holds the 32x32 register file with a
//                write-through writeback port, detects load-use and branch
//                data hazards, resolves beq/bne early and drives ID/EX.
//  Optional    : `define ID_BRANCH_EN enables early branch resolution and
//                branch hazard stalls.  Without it, opcode 1100011 is a NOP,
//                and branch_taken, if_flush and branch_target are 0.
//  Ports       : clk, reset (sync, active-high)
//                instr, pc_plus4            - IF/ID register contents
//                wb_we, wb_rd, wb_data      - register file writeback
//                exmem_reg_write, exmem_rd  - EX/MEM destination
//                hold_pc, hold_ifid, if_flush, branch_taken, branch_target
//                idex_*                     - ID/EX pipeline register
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            exmem_reg_write,
    input  logic [4:0]      exmem_rd,
    output logic            hold_pc,
    output logic            hold_ifid,
    output logic            if_flush,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] idex_pc_plus4,
    output logic [XLEN-1:0] idex_rs1_data,
    output logic [XLEN-1:0] idex_rs2_data,
    output logic [XLEN-1:0] idex_imm,
    output logic [4:0]      idex_rs1,
    output logic [4:0]      idex_rs2,
    output logic [4:0]      idex_rd,
    output logic [3:0]      idex_alu_op,
    output logic            idex_alu_src,
    output logic            idex_mem_read,
    output logic            idex_mem_write,
    output logic            idex_reg_write,
    output logic            idex_mem_to_reg
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_SUB = 4'd1;
    localparam logic [3:0] c_ALU_AND = 4'd2;
    localparam logic [3:0] c_ALU_OR  = 4'd3;
    localparam logic [3:0] c_ALU_XOR = 4'd4;
    localparam logic [3:0] c_ALU_SLL = 4'd5;
    localparam logic [3:0] c_ALU_SRL = 4'd6;
    localparam logic [3:0] c_ALU_SRA = 4'd7;
    localparam logic [3:0] c_ALU_SLT = 4'd8;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_b30;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;

    assign w_opcode     = instr[6:0];
    assign w_funct3     = instr[14:12];
    assign w_funct7_b30 = instr[30];
    assign w_rs1        = instr[19:15];
    assign w_rs2        = instr[24:20];
    assign w_rd         = instr[11:7];

    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;

    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    // funct3 -> ALU op; sub only exists for R-type, sra for both forms
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic b30,
                                           input logic allow_sub);
        logic [3:0] op;
        op = c_ALU_ADD;
        case (f3)
            3'd0:    op = (allow_sub && b30) ? c_ALU_SUB : c_ALU_ADD;
            3'd1:    op = c_ALU_SLL;
            3'd2:    op = c_ALU_SLT;
            3'd4:    op = c_ALU_XOR;
            3'd5:    op = b30 ? c_ALU_SRA : c_ALU_SRL;
            3'd6:    op = c_ALU_OR;
            3'd7:    op = c_ALU_AND;
            default: op = c_ALU_ADD;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [3:0]      w_alu_op;
    logic            w_alu_src;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_reg_write;
    logic            w_mem_to_reg;
    logic [XLEN-1:0] w_imm;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_is_branch;

    always_comb begin
        w_alu_op     = c_ALU_ADD;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_imm        = '0;
        w_use_rs1    = 1'b0;
        w_use_rs2    = 1'b0;
        w_is_branch  = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_alu_op    = alu_sel(w_funct3, w_funct7_b30, 1'b1);
                w_reg_write = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
            c_OP_I: begin
                w_alu_op    = alu_sel(w_funct3, w_funct7_b30, 1'b0);
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_imm       = w_imm_i;
                w_use_rs1   = 1'b1;
            end
            c_OP_LOAD: begin
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_imm        = w_imm_i;
                w_use_rs1    = 1'b1;
            end
            c_OP_STORE: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_imm       = w_imm_s;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
`ifdef ID_BRANCH_EN
            // Branches are resolved here; they enter ID/EX with control 0
            c_OP_BRANCH: begin
                w_is_branch = 1'b1;
                w_imm       = w_imm_b;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file with write-through bypass
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        w_rs1_data = r_regs[w_rs1];
        w_rs2_data = r_regs[w_rs2];
        if (wb_we && (wb_rd == w_rs1)) w_rs1_data = wb_data;
        if (wb_we && (wb_rd == w_rs2)) w_rs2_data = wb_data;
        if (w_rs1 == 5'd0) w_rs1_data = '0;
        if (w_rs2 == 5'd0) w_rs2_data = '0;
    end

    // ------------------------------------------------------------------
    // ID/EX register state (read back for hazard detection)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_idex_pc_plus4;
    logic [XLEN-1:0] r_idex_rs1_data;
    logic [XLEN-1:0] r_idex_rs2_data;
    logic [XLEN-1:0] r_idex_imm;
    logic [4:0]      r_idex_rs1;
    logic [4:0]      r_idex_rs2;
    logic [4:0]      r_idex_rd;
    logic [3:0]      r_idex_alu_op;
    logic            r_idex_alu_src;
    logic            r_idex_mem_read;
    logic            r_idex_mem_write;
    logic            r_idex_reg_write;
    logic            r_idex_mem_to_reg;

    // ------------------------------------------------------------------
    // Hazard detection and branch resolution
    // ------------------------------------------------------------------
    logic w_load_use;
    logic w_branch_hazard;
    logic w_stall;
    logic w_taken;
    logic [XLEN-1:0] w_target;

    assign w_load_use = r_idex_mem_read && (r_idex_rd != 5'd0) &&
                        ((w_use_rs1 && (r_idex_rd == w_rs1)) ||
                         (w_use_rs2 && (r_idex_rd == w_rs2)));

`ifdef ID_BRANCH_EN
    // A branch needs both operands now; any in-flight producer stalls it
    logic w_rs1_pending;
    logic w_rs2_pending;
    logic w_equal;

    assign w_rs1_pending = (w_rs1 != 5'd0) &&
                           ((r_idex_reg_write && (r_idex_rd == w_rs1)) ||
                            (exmem_reg_write && (exmem_rd == w_rs1)));
    assign w_rs2_pending = (w_rs2 != 5'd0) &&
                           ((r_idex_reg_write && (r_idex_rd == w_rs2)) ||
                            (exmem_reg_write && (exmem_rd == w_rs2)));
    assign w_branch_hazard = w_is_branch && (w_rs1_pending || w_rs2_pending);
    assign w_equal         = (w_rs1_data == w_rs2_data);
    assign w_taken  = w_is_branch && !w_stall &&
                      (((w_funct3 == 3'd0) && w_equal) ||
                       ((w_funct3 == 3'd1) && !w_equal));
    // pc_plus4 - 4 is the branch's own address
    assign w_target = pc_plus4 - XLEN'(4) + w_imm_b;
`else
    logic w_unused_branch;
    assign w_unused_branch = ^{exmem_reg_write, exmem_rd, w_is_branch};
    assign w_branch_hazard = 1'b0;
    assign w_taken         = 1'b0;
    assign w_target        = '0;
`endif

    assign w_stall = w_load_use || w_branch_hazard;

    assign hold_pc       = !reset && w_stall;
    assign hold_ifid     = !reset && (w_stall || w_taken);
    assign if_flush      = !reset && w_taken;
    assign branch_taken  = !reset && w_taken;
    assign branch_target = reset ? '0 : w_target;

    // ------------------------------------------------------------------
    // ID/EX pipeline register: a stall loads an all-zero bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || w_stall) begin
            r_idex_pc_plus4   <= '0;
            r_idex_rs1_data   <= '0;
            r_idex_rs2_data   <= '0;
            r_idex_imm        <= '0;
            r_idex_rs1        <= '0;
            r_idex_rs2        <= '0;
            r_idex_rd         <= '0;
            r_idex_alu_op     <= '0;
            r_idex_alu_src    <= 1'b0;
            r_idex_mem_read   <= 1'b0;
            r_idex_mem_write  <= 1'b0;
            r_idex_reg_write  <= 1'b0;
            r_idex_mem_to_reg <= 1'b0;
        end else begin
            r_idex_pc_plus4   <= pc_plus4;
            r_idex_rs1_data   <= w_rs1_data;
            r_idex_rs2_data   <= w_rs2_data;
            r_idex_imm        <= w_imm;
            r_idex_rs1        <= w_rs1;
            r_idex_rs2        <= w_rs2;
            r_idex_rd         <= w_rd;
            r_idex_alu_op     <= w_alu_op;
            r_idex_alu_src    <= w_alu_src;
            r_idex_mem_read   <= w_mem_read;
            r_idex_mem_write  <= w_mem_write;
            r_idex_reg_write  <= w_reg_write;
            r_idex_mem_to_reg <= w_mem_to_reg;
        end
    end

    assign idex_pc_plus4   = r_idex_pc_plus4;
    assign idex_rs1_data   = r_idex_rs1_data;
    assign idex_rs2_data   = r_idex_rs2_data;
    assign idex_imm        = r_idex_imm;
    assign idex_rs1        = r_idex_rs1;
    assign idex_rs2        = r_idex_rs2;
    assign idex_rd         = r_idex_rd;
    assign idex_alu_op     = r_idex_alu_op;
    assign idex_alu_src    = r_idex_alu_src;
    assign idex_mem_read   = r_idex_mem_read;
    assign idex_mem_write  = r_idex_mem_write;
    assign idex_reg_write  = r_idex_reg_write;
    assign idex_mem_to_reg = r_idex_mem_to_reg;

endmodule
`default_nettype wire
